// File: rtl/credit_retry_requester_pkg.sv
// Shared types for the credit/retry requester: slot states, request record,
// and the lowest-index priority pick used to order credited reissues.
package credit_retry_requester_pkg;
  localparam int ID_W_DEF   = 3;
  localparam int DATA_W_DEF = 5;

  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_PARKED  = 2'd1,
    SLOT_GRANTED = 2'd2
  } slot_state_t;

  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [DATA_W_DEF-1:0] payload;
    logic                  credit;
  } req_t;

  // Index of the lowest set bit, or -1 when none is set.
  function automatic int lowest_set(input logic [31:0] v);
    for (int i = 0; i < 32; i++)
      if (v[i]) return i;
    return -1;
  endfunction
endpackage

// File: rtl/credit_retry_requester.sv
// Requester in front of the credit/deadlock buffer: presents requests, parks
// retried ones per ID and reissues them with the credit flag once granted.
module credit_retry_requester
  import credit_retry_requester_pkg::*;
#(
  parameter int ID_W   = ID_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid_i,
  input  logic [ID_W-1:0]   src_id_i,
  input  logic [DATA_W-1:0] src_payload_i,
  output logic              src_ready_o,
  output logic              rx_valid_o,
  output logic [ID_W-1:0]   rx_id_o,
  output logic [DATA_W-1:0] rx_payload_o,
  output logic              rx_credit_o,
  input  logic              rx_ready_i,
  input  logic              rx_retry_i,
  input  logic              credit_gnt_i,
  input  logic [ID_W-1:0]   credit_id_i,
  output logic [ID_W:0]     pending_cnt_o,
  output logic              err_o
);
  localparam int SLOTS = 1 << ID_W;

  slot_state_t       slot_st [SLOTS];
  slot_state_t       slot_nx [SLOTS];
  logic [DATA_W-1:0] slot_pl [SLOTS];

  logic              or_v, or_c, or_v_nx, or_c_nx;
  logic [ID_W-1:0]   or_id, or_id_nx;
  logic [DATA_W-1:0] or_pl, or_pl_nx;
  logic [ID_W:0]     cnt, cnt_nx;
  logic              err, err_nx;

  logic              leave, park, loadable, any_gr, load_gr, gnt_hit;
  logic [31:0]       gr_vec;
  int                sel;
  logic [ID_W-1:0]   sel_id;

  // A credited request cannot be parked again; ready wins over retry.
  assign leave    = or_v & (rx_ready_i | rx_retry_i);
  assign park     = or_v & rx_retry_i & ~rx_ready_i & ~or_c;
  assign loadable = ~or_v | leave;

  always_comb begin
    gr_vec = '0;
    for (int i = 0; i < SLOTS; i++)
      gr_vec[i] = (slot_st[i] == SLOT_GRANTED);
    sel     = lowest_set(gr_vec);
    any_gr  = (sel >= 0);
    sel_id  = ID_W'(sel);
    load_gr = loadable & any_gr;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      or_v  <= 1'b0;
      or_c  <= 1'b0;
      or_id <= '0;
      or_pl <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      for (int i = 0; i < SLOTS; i++) slot_st[i] <= SLOT_IDLE;
    end else begin
      or_v  <= or_v_nx;
      or_c  <= or_c_nx;
      or_id <= or_id_nx;
      or_pl <= or_pl_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
      for (int i = 0; i < SLOTS; i++) slot_st[i] <= slot_nx[i];
    end
  end

  always_ff @(posedge clk) begin
    if (park) slot_pl[or_id] <= or_pl;
  end

  // Next state
  always_comb begin
    gnt_hit = credit_gnt_i & ((slot_st[credit_id_i] == SLOT_PARKED) |
                              (park & (or_id == credit_id_i)));
    err_nx  = err | (credit_gnt_i & ~gnt_hit) | (or_v & rx_retry_i & or_c) |
              (or_v & rx_ready_i & rx_retry_i);

    cnt_nx = '0;
    for (int i = 0; i < SLOTS; i++) begin
      slot_nx[i] = slot_st[i];
      if (park && or_id == ID_W'(i))
        slot_nx[i] = (gnt_hit && credit_id_i == ID_W'(i)) ? SLOT_GRANTED : SLOT_PARKED;
      else if (gnt_hit && credit_id_i == ID_W'(i))
        slot_nx[i] = SLOT_GRANTED;
      if (load_gr && sel_id == ID_W'(i))
        slot_nx[i] = SLOT_IDLE;
      cnt_nx = cnt_nx + (ID_W+1)'(slot_nx[i] != SLOT_IDLE);
    end

    or_v_nx  = or_v;
    or_c_nx  = or_c;
    or_id_nx = or_id;
    or_pl_nx = or_pl;
    if (loadable) begin
      if (any_gr) begin
        or_v_nx  = 1'b1;
        or_c_nx  = 1'b1;
        or_id_nx = sel_id;
        or_pl_nx = slot_pl[sel_id];
      end else if (src_valid_i && src_ready_o) begin
        or_v_nx  = 1'b1;
        or_c_nx  = 1'b0;
        or_id_nx = src_id_i;
        or_pl_nx = src_payload_i;
      end else begin
        or_v_nx  = 1'b0;
      end
    end
  end

  // Outputs. The last ready term keeps a second same-ID request out of the
  // OR while the first is being parked, so an ID never parks twice.
  always_comb begin
    src_ready_o   = loadable & ~any_gr & (slot_st[src_id_i] == SLOT_IDLE) &
                    ~(or_v & or_c & (or_id == src_id_i)) &
                    ~(park & (or_id == src_id_i));
    rx_valid_o    = or_v;
    rx_id_o       = or_id;
    rx_payload_o  = or_pl;
    rx_credit_o   = or_c;
    pending_cnt_o = cnt;
    err_o         = err;
  end
endmodule
